// File: rtl/ab_code_decoder_pkg.sv
// Shared code-word constants and event encoding for the A/B code link.
// The transmitter imports the same package so both ends agree on the codes.
package ab_code_decoder_pkg;

  localparam logic [1:0] CODE_A = 2'b01;
  localparam logic [1:0] CODE_B = 2'b10;

  typedef enum logic {
    EV_B = 1'b0,
    EV_A = 1'b1
  } ev_t;

  typedef enum logic [1:0] {
    DEC_A   = 2'd0,
    DEC_B   = 2'd1,
    DEC_ERR = 2'd2
  } dec_t;

  // y[0] is a don't-care for A words. An unknown compare result falls through
  // both branches, so an X/Z in a checked bit classifies as an error.
  function automatic dec_t decode_word(input logic [1:0] y, input logic [1:0] z);
    dec_t d;
    d = DEC_ERR;
    if ((z == CODE_A) && (y[1] == 1'b1)) begin
      d = DEC_A;
    end else if ((z == CODE_B) && (y == 2'b00)) begin
      d = DEC_B;
    end
    return d;
  endfunction

endpackage

// File: rtl/ab_event_fifo.sv
// DEPTH-entry event FIFO with flop storage, wrapping pointers and an explicit
// occupancy counter; clear has priority over push and pop.
module ab_event_fifo
  import ab_code_decoder_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic push,
  input  ev_t  push_ev,
  input  logic pop,
  output logic not_full,
  output logic not_empty,
  output ev_t  head_ev
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] DEPTH_C = (AW + 1)'(DEPTH);

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  ev_t           mem_q [DEPTH];
  ev_t           mem_d [DEPTH];
  logic          do_push, do_pop;

  assign not_full  = (count_q != DEPTH_C);
  assign not_empty = (count_q != '0);
  assign head_ev   = mem_q[rd_ptr_q];

  always_comb begin
    do_push  = push & not_full;
    do_pop   = pop & not_empty;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    mem_d    = mem_q;
    if (clear) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) begin
        mem_d[wr_ptr_q] = push_ev;
        wr_ptr_d        = wr_ptr_q + 1'b1;
      end
      if (do_pop) begin
        rd_ptr_d = rd_ptr_q + 1'b1;
      end
      // Push and pop together leave the occupancy unchanged.
      count_d = count_q + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= EV_B;
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      mem_q    <= mem_d;
    end
  end

endmodule

// File: rtl/ab_code_decoder.sv
// Decodes 4-bit y/z code words into A/B events queued for a consumer, with
// saturating event/error statistics and a one-cycle error pulse.
module ab_code_decoder
  import ab_code_decoder_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       y,
  input  logic [1:0]       z,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             a_out,
  output logic             b_out,
  output logic             err,
  output logic [CNT_W-1:0] a_cnt,
  output logic [CNT_W-1:0] b_cnt,
  output logic [CNT_W-1:0] err_cnt
);

  // Handshake: a word transfers on a rising edge where in_valid & in_ready,
  // an event pops where out_valid & out_ready; clear drops both that cycle.

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  dec_t             dec;
  logic             accept;
  logic             fifo_push;
  ev_t              fifo_push_ev;
  logic             fifo_not_empty;
  ev_t              fifo_head;
  logic [CNT_W-1:0] a_cnt_q, a_cnt_d;
  logic [CNT_W-1:0] b_cnt_q, b_cnt_d;
  logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
  logic             err_q, err_d;

  assign dec          = decode_word(y, z);
  assign accept       = in_valid & in_ready & ~clear;
  assign fifo_push    = accept & ((dec == DEC_A) | (dec == DEC_B));
  assign fifo_push_ev = (dec == DEC_A) ? EV_A : EV_B;

  ab_event_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear    (clear),
    .push     (fifo_push),
    .push_ev  (fifo_push_ev),
    .pop      (out_valid & out_ready),
    .not_full (in_ready),
    .not_empty(fifo_not_empty),
    .head_ev  (fifo_head)
  );

  assign out_valid = fifo_not_empty;
  assign a_out     = fifo_not_empty & (fifo_head == EV_A);
  assign b_out     = fifo_not_empty & (fifo_head == EV_B);

  // Statistics count acceptances, so they lead the consumer's view of the FIFO.
  always_comb begin
    a_cnt_d   = a_cnt_q;
    b_cnt_d   = b_cnt_q;
    err_cnt_d = err_cnt_q;
    err_d     = 1'b0;
    if (clear) begin
      a_cnt_d   = '0;
      b_cnt_d   = '0;
      err_cnt_d = '0;
    end else if (accept) begin
      case (dec)
        DEC_A: if (a_cnt_q != CNT_MAX) a_cnt_d = a_cnt_q + 1'b1;
        DEC_B: if (b_cnt_q != CNT_MAX) b_cnt_d = b_cnt_q + 1'b1;
        default: begin
          err_d = 1'b1;
          if (err_cnt_q != CNT_MAX) err_cnt_d = err_cnt_q + 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_cnt_q   <= '0;
      b_cnt_q   <= '0;
      err_cnt_q <= '0;
      err_q     <= 1'b0;
    end else begin
      a_cnt_q   <= a_cnt_d;
      b_cnt_q   <= b_cnt_d;
      err_cnt_q <= err_cnt_d;
      err_q     <= err_d;
    end
  end

  assign a_cnt   = a_cnt_q;
  assign b_cnt   = b_cnt_q;
  assign err_cnt = err_cnt_q;
  assign err     = err_q;

endmodule

// File: tb/tb_ab_code_decoder.sv
// Bench for ab_code_decoder: directed scenarios plus random traffic, checked by
// a queue-based reference model and a negedge monitor.
module tb_ab_code_decoder;

  localparam int DEPTH = 4;
  localparam int CNT_W = 8;
  localparam int CMAX  = (1 << CNT_W) - 1;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic             clear, in_valid, out_ready;
  logic [1:0]       y, z;
  logic             in_ready, out_valid, a_out, b_out, err;
  logic [CNT_W-1:0] a_cnt, b_cnt, err_cnt;

  ab_code_decoder #(
    .DEPTH(DEPTH),
    .CNT_W(CNT_W)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear    (clear),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .y        (y),
    .z        (z),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .a_out    (a_out),
    .b_out    (b_out),
    .err      (err),
    .a_cnt    (a_cnt),
    .b_cnt    (b_cnt),
    .err_cnt  (err_cnt)
  );

  int checks   = 0;
  int failures = 0;

  function automatic void check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endfunction

  // ---------------- reference model ----------------
  // Expected events in arrival order, encoded as {a_out,b_out}.
  logic [1:0] exp_q[$];
  int         occ, exp_a, exp_b, exp_e;
  logic       exp_err;

  logic m_a, m_b, m_acc, m_pop;
  assign m_a   = (z == 2'd1) && (y >= 2'd2);
  assign m_b   = (z == 2'd2) && (y == 2'd0);
  assign m_acc = in_valid && (occ < DEPTH);
  assign m_pop = (occ > 0) && out_ready;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n || clear) begin
      exp_q.delete();
      occ     <= 0;
      exp_a   <= 0;
      exp_b   <= 0;
      exp_e   <= 0;
      exp_err <= 1'b0;
    end else begin
      exp_err <= m_acc && !m_a && !m_b;
      if (m_acc && m_a) begin
        exp_q.push_back(2'b10);
        if (exp_a < CMAX) exp_a <= exp_a + 1;
      end
      if (m_acc && m_b) begin
        exp_q.push_back(2'b01);
        if (exp_b < CMAX) exp_b <= exp_b + 1;
      end
      if (m_acc && !m_a && !m_b && exp_e < CMAX) exp_e <= exp_e + 1;
      occ <= occ + ((m_acc && (m_a || m_b)) ? 1 : 0) - (m_pop ? 1 : 0);
    end
  end

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    check("in_ready", int'(in_ready), int'(occ < DEPTH));
    check("out_valid", int'(out_valid), int'(occ > 0));
    check("err", int'(err), int'(exp_err));
    check("a_cnt", int'(a_cnt), exp_a);
    check("b_cnt", int'(b_cnt), exp_b);
    check("err_cnt", int'(err_cnt), exp_e);
    if (out_valid) begin
      check("head_ab", int'({a_out, b_out}), (exp_q.size() > 0) ? int'(exp_q[0]) : 0);
      if (out_ready && !clear && rst_n && exp_q.size() > 0) void'(exp_q.pop_front());
    end else begin
      check("idle_ab", int'({a_out, b_out}), 0);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [1:0] yy, input logic [1:0] zz);
    in_valid = 1'b1;
    y        = yy;
    z        = zz;
    step();
    in_valid = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_in_ready"}, int'(in_ready), 1);
    check({tag, "_out_valid"}, int'(out_valid), 0);
    check({tag, "_ab"}, int'({a_out, b_out}), 0);
    check({tag, "_err"}, int'(err), 0);
    check({tag, "_cnts"}, int'(a_cnt) + int'(b_cnt) + int'(err_cnt), 0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst_n = 1'b0; clear = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    y = 2'b00; z = 2'b00;
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("por");
    rst_n = 1'b1;
    step();

    // A word with y[0]=0 decodes as A one cycle after acceptance
    out_ready = 1'b1;
    send(2'b10, 2'b01);
    @(negedge clk);
    check("a_first_valid", int'(out_valid), 1);
    check("a_first_ab", int'({a_out, b_out}), 2);
    check("a_first_cnt", int'(a_cnt), 1);
    step();

    // z=11 is an error: one-cycle pulse, nothing queued
    send(2'b00, 2'b11);
    @(negedge clk);
    check("err_pulse", int'(err), 1);
    check("err_cnt1", int'(err_cnt), 1);
    check("err_no_event", int'(out_valid), 0);
    step();
    @(negedge clk);
    check("err_pulse_end", int'(err), 0);
    step();

    // Fill with four B words under back-pressure; a fifth is refused
    out_ready = 1'b0;
    in_valid = 1'b1; y = 2'b00; z = 2'b10;
    repeat (4) step();
    @(negedge clk);
    check("full_in_ready", int'(in_ready), 0);
    check("full_b_cnt", int'(b_cnt), 4);
    step();
    in_valid = 1'b0;
    @(negedge clk);
    check("fifth_refused_b_cnt", int'(b_cnt), 4);
    step();
    out_ready = 1'b1;
    repeat (5) step();

    // Two queued, then simultaneous push+pop keeps order A,B,A
    out_ready = 1'b0;
    send(2'b11, 2'b01);
    send(2'b00, 2'b10);
    in_valid = 1'b1; y = 2'b10; z = 2'b01; out_ready = 1'b1;
    step();
    in_valid = 1'b0; out_ready = 1'b0;
    @(negedge clk);
    check("pp_head_b", int'({a_out, b_out}), 1);
    check("pp_in_ready", int'(in_ready), 1);
    step();
    out_ready = 1'b1;
    repeat (3) step();

    // clear flushes the queue and counters and drops the word presented with it
    out_ready = 1'b0;
    send(2'b00, 2'b10);
    send(2'b10, 2'b01);
    clear = 1'b1; in_valid = 1'b1; y = 2'b00; z = 2'b11;
    step();
    clear = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    check("clr_out_valid", int'(out_valid), 0);
    check("clr_err", int'(err), 0);
    check("clr_cnts", int'(a_cnt) + int'(b_cnt) + int'(err_cnt), 0);
    step();

    // Saturation: 256 A words from zero hold at 255
    out_ready = 1'b1;
    in_valid = 1'b1; y = 2'b10; z = 2'b01;
    repeat (256) step();
    @(negedge clk);
    check("a_sat", int'(a_cnt), 255);
    repeat (4) step();
    in_valid = 1'b0;
    @(negedge clk);
    check("a_sat_hold", int'(a_cnt), 255);
    repeat (3) step();

    // Asynchronous reset with three events queued
    out_ready = 1'b0;
    send(2'b10, 2'b01);
    send(2'b00, 2'b10);
    send(2'b11, 2'b01);
    #2 rst_n = 1'b0;
    #1;
    check_reset_outputs("mid_rst");
    step();
    rst_n = 1'b1;
    step();
    send(2'b00, 2'b10);
    @(negedge clk);
    check("post_rst_b", int'({a_out, b_out}), 1);
    step();
    out_ready = 1'b1;
    repeat (2) step();

    // Random traffic
    for (int i = 0; i < 2000; i++) begin
      in_valid = ($urandom_range(0, 3) != 0);
      y        = 2'($urandom_range(0, 3));
      case ($urandom_range(0, 3))
        0: z = 2'b01;
        1: z = 2'b10;
        default: z = 2'($urandom_range(0, 3));
      endcase
      out_ready = (i % 400 < 200) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
      clear     = ($urandom_range(0, 63) == 0);
      step();
    end
    in_valid = 1'b0; clear = 1'b0; out_ready = 1'b1;
    repeat (DEPTH + 4) step();
    @(negedge clk);
    check("sb_drained", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
